// File: rtl/alu_ctrl_exec_if.sv
// Bus between the decode/execute block and its neighbours: instruction in,
// register read data in, decode controls, ALU result and flags out.
interface alu_ctrl_exec_if;
    logic [8:0] instr;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic [1:0] r_addr1;
    logic [1:0] r_addr2;
    logic [1:0] w_addr;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       mem_write;
    logic       mem_read;
    logic [4:0] lut_index;
    logic       branch_taken;
    logic [7:0] result;
    logic       carry;
    logic       eq_flag;
    logic       lt_flag;

    modport master (
        output instr, rdata_a, rdata_b,
        input  r_addr1, r_addr2, w_addr, reg_write, wb_sel, mem_write, mem_read,
               lut_index, branch_taken, result, carry, eq_flag, lt_flag
    );

    modport slave (
        input  instr, rdata_a, rdata_b,
        output r_addr1, r_addr2, w_addr, reg_write, wb_sel, mem_write, mem_read,
               lut_index, branch_taken, result, carry, eq_flag, lt_flag
    );
endinterface

// File: rtl/alu_ctrl_exec.sv
// Single-cycle decode/execute for the 9-bit, four-register 8-bit core.
// Define ALU_SIGNED_CMP_EN to make SLT/SLTE and the lt flag signed compares.
module alu_ctrl_exec (
    input  logic           clk,
    input  logic           reset,
    alu_ctrl_exec_if.slave bus
);
    localparam logic [1:0] T_R = 2'b00, T_MEM = 2'b01, T_BR = 2'b10, T_SH = 2'b11;

    localparam logic [2:0] R_AND = 3'd0, R_OR = 3'd1, R_XOR = 3'd2, R_ADD = 3'd3,
                           R_SUB = 3'd4, R_SLT = 3'd5, R_SLTE = 3'd6, R_SEQ = 3'd7;

    localparam logic [2:0] M_SB = 3'd0, M_LB = 3'd1, M_LL = 3'd2, M_LL2 = 3'd3,
                           M_LIL = 3'd4, M_LIU = 3'd5, M_LLM = 3'd6;

    localparam logic [1:0] B_EQ = 2'd0, B_LT = 2'd1, B_LTE = 2'd2, B_UN = 2'd3;
    localparam logic [1:0] S_LSL = 2'd0, S_LSR = 2'd1, S_LSI = 2'd2, S_RSI = 2'd3;

    logic [1:0] typ, op2, rd, rs;
    logic [2:0] op3;
    logic [3:0] imm4;
    logic [4:0] imm5;

    logic [7:0] a, b, op_b;
    logic [8:0] sum;
    logic [7:0] diff;
    logic       cmp_eq, cmp_ult, cmp_lt;

    logic       eq_q, lt_q;
    logic [4:0] lut_q;
    logic       flag_upd, ll_upd;

    assign typ  = bus.instr[8:7];
    assign op3  = bus.instr[6:4];
    assign op2  = bus.instr[6:5];
    assign rd   = bus.instr[3:2];
    assign rs   = bus.instr[1:0];
    assign imm4 = bus.instr[3:0];
    assign imm5 = bus.instr[4:0];

    assign a       = bus.rdata_a;
    assign b       = bus.rdata_b;
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = a - b;
    assign cmp_eq  = (a == b);
    assign cmp_ult = (a < b);
`ifdef ALU_SIGNED_CMP_EN
    assign cmp_lt  = ($signed(a) < $signed(b));
`else
    assign cmp_lt  = cmp_ult;
`endif

    always_comb begin
        bus.r_addr1      = rd;
        bus.r_addr2      = rs;
        bus.w_addr       = rd;
        bus.reg_write    = 1'b0;
        bus.wb_sel       = 2'd0;
        bus.mem_write    = 1'b0;
        bus.mem_read     = 1'b0;
        bus.lut_index    = lut_q;
        bus.branch_taken = 1'b0;
        bus.result       = 8'h00;
        bus.carry        = 1'b0;
        op_b             = b;
        flag_upd         = 1'b0;
        ll_upd           = 1'b0;
        unique case (typ)
            T_R: begin
                bus.reg_write = 1'b1;
                unique case (op3)
                    R_AND:  bus.result = a & b;
                    R_OR:   bus.result = a | b;
                    R_XOR:  bus.result = a ^ b;
                    R_ADD:  begin bus.result = sum[7:0]; bus.carry = sum[8]; end
                    R_SUB:  begin bus.result = diff; bus.carry = cmp_ult; flag_upd = 1'b1; end
                    R_SLT:  begin bus.result = {7'd0, cmp_lt}; flag_upd = 1'b1; end
                    R_SLTE: begin bus.result = {7'd0, cmp_lt | cmp_eq}; flag_upd = 1'b1; end
                    R_SEQ:  begin bus.result = {7'd0, cmp_eq}; flag_upd = 1'b1; end
                endcase
            end
            T_MEM: begin
                unique case (op3)
                    M_SB:  bus.mem_write = 1'b1;
                    M_LB:  begin bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.wb_sel = 2'd1; end
                    M_LL, M_LL2: ll_upd = 1'b1;
                    M_LIL: begin
                        bus.r_addr1 = 2'd0; bus.w_addr = 2'd0; bus.reg_write = 1'b1;
                        bus.result  = {a[7:4], imm4};
                    end
                    M_LIU: begin
                        bus.r_addr1 = 2'd0; bus.w_addr = 2'd0; bus.reg_write = 1'b1;
                        bus.result  = {imm4, a[3:0]};
                    end
                    M_LLM: begin bus.reg_write = 1'b1; bus.wb_sel = 2'd2; end
                    default: ;
                endcase
            end
            T_BR: begin
                bus.lut_index = imm5;
                unique case (op2)
                    B_EQ:  bus.branch_taken = eq_q;
                    B_LT:  bus.branch_taken = lt_q;
                    B_LTE: bus.branch_taken = eq_q | lt_q;
                    B_UN:  bus.branch_taken = 1'b1;
                endcase
            end
            T_SH: begin
                bus.reg_write = 1'b1;
                if (op2 == S_LSL || op2 == S_LSR) begin
                    bus.r_addr1 = bus.instr[4:3];
                    bus.w_addr  = bus.instr[4:3];
                    bus.r_addr2 = bus.instr[2:1];
                end else begin
                    bus.r_addr1 = 2'd0;
                    bus.w_addr  = 2'd0;
                    op_b        = {3'd0, imm5};
                end
                // Any amount of 8 or more shifts every bit out.
                if (op_b > 8'd7)
                    bus.result = 8'h00;
                else if (op2 == S_LSL || op2 == S_LSI)
                    bus.result = a << op_b[2:0];
                else
                    bus.result = a >> op_b[2:0];
            end
        endcase
    end

    // LL and LL2 differ only in op bit 0, which is the top bit of the index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            lut_q <= 5'd0;
        end else begin
            if (flag_upd) begin
                eq_q <= cmp_eq;
                lt_q <= cmp_lt;
            end
            if (ll_upd)
                lut_q <= {op3[0], imm4};
        end
    end

    assign bus.eq_flag = eq_q;
    assign bus.lt_flag = lt_q;
endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed bench for alu_ctrl_exec; a four-entry register array feeds the
// read ports from the DUT's own read addresses.
module tb_alu_ctrl_exec;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] rf [0:3];

    always #5 clk = ~clk;

    alu_ctrl_exec_if bus ();
    alu_ctrl_exec dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus.rdata_a = rf[bus.r_addr1];
    assign bus.rdata_b = rf[bus.r_addr2];

    // drive a new instruction just after the falling edge, then let it settle
    task automatic issue(input logic [8:0] ins);
        @(negedge clk);
        bus.instr = ins;
        #1;
    endtask

    task automatic test_reset;
        bus.instr = 9'b01_111_0000;
        reset = 1'b1;
        #12;
        n_cmp++; if (bus.eq_flag !== 1'b0) begin n_err++; $display("FAIL reset_eq got %b want 0", bus.eq_flag); end
        n_cmp++; if (bus.lt_flag !== 1'b0) begin n_err++; $display("FAIL reset_lt got %b want 0", bus.lt_flag); end
        n_cmp++; if (bus.lut_index !== 5'd0) begin n_err++; $display("FAIL reset_lut got %h want 00", bus.lut_index); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_rtype;
        rf[1] = 8'hF0; rf[2] = 8'h20;
        issue({2'b00, 3'd3, 2'd1, 2'd2});
        n_cmp++; if (bus.result !== 8'h10) begin n_err++; $display("FAIL add_result got %h want 10", bus.result); end
        n_cmp++; if (bus.carry !== 1'b1) begin n_err++; $display("FAIL add_carry got %b want 1", bus.carry); end
        n_cmp++; if (bus.reg_write !== 1'b1 || bus.w_addr !== 2'd1 || bus.wb_sel !== 2'd0)
            begin n_err++; $display("FAIL add_ctrl got we=%b wa=%0d wb=%0d want 1/1/0", bus.reg_write, bus.w_addr, bus.wb_sel); end
        n_cmp++; if (bus.r_addr1 !== 2'd1 || bus.r_addr2 !== 2'd2)
            begin n_err++; $display("FAIL add_raddr got %0d/%0d want 1/2", bus.r_addr1, bus.r_addr2); end
        rf[2] = 8'h3C;
        issue({2'b00, 3'd0, 2'd1, 2'd2});
        n_cmp++; if (bus.result !== 8'h30) begin n_err++; $display("FAIL and got %h want 30", bus.result); end
        issue({2'b00, 3'd1, 2'd1, 2'd2});
        n_cmp++; if (bus.result !== 8'hFC) begin n_err++; $display("FAIL or got %h want fc", bus.result); end
        issue({2'b00, 3'd2, 2'd1, 2'd2});
        n_cmp++; if (bus.result !== 8'hCC || bus.carry !== 1'b0)
            begin n_err++; $display("FAIL xor got %h c=%b want cc c=0", bus.result, bus.carry); end
        // SUB 0x20 - 0xF0: unsigned borrow; signed 32 > -16
        rf[1] = 8'h20; rf[2] = 8'hF0;
        issue({2'b00, 3'd4, 2'd1, 2'd2});
        n_cmp++; if (bus.result !== 8'h30 || bus.carry !== 1'b1)
            begin n_err++; $display("FAIL sub got %h c=%b want 30 c=1", bus.result, bus.carry); end
        @(negedge clk);
        bus.instr = 9'b01_111_0000;
        #1;
`ifdef ALU_SIGNED_CMP_EN
        n_cmp++; if (bus.lt_flag !== 1'b0 || bus.eq_flag !== 1'b0)
            begin n_err++; $display("FAIL sub_flags got eq=%b lt=%b want 0/0", bus.eq_flag, bus.lt_flag); end
`else
        n_cmp++; if (bus.lt_flag !== 1'b1 || bus.eq_flag !== 1'b0)
            begin n_err++; $display("FAIL sub_flags got eq=%b lt=%b want 0/1", bus.eq_flag, bus.lt_flag); end
`endif
    endtask

    task automatic test_compare;
        rf[0] = 8'h80; rf[1] = 8'h01;
        issue({2'b00, 3'd5, 2'd0, 2'd1});
`ifdef ALU_SIGNED_CMP_EN
        n_cmp++; if (bus.result !== 8'h01) begin n_err++; $display("FAIL slt got %h want 01", bus.result); end
`else
        n_cmp++; if (bus.result !== 8'h00) begin n_err++; $display("FAIL slt got %h want 00", bus.result); end
`endif
        issue({2'b00, 3'd6, 2'd1, 2'd0});
`ifdef ALU_SIGNED_CMP_EN
        n_cmp++; if (bus.lt_flag !== 1'b1) begin n_err++; $display("FAIL slt_flag got %b want 1", bus.lt_flag); end
        n_cmp++; if (bus.result !== 8'h00) begin n_err++; $display("FAIL slte got %h want 00", bus.result); end
`else
        n_cmp++; if (bus.lt_flag !== 1'b0) begin n_err++; $display("FAIL slt_flag got %b want 0", bus.lt_flag); end
        n_cmp++; if (bus.result !== 8'h01) begin n_err++; $display("FAIL slte got %h want 01", bus.result); end
`endif
        rf[2] = 8'h44; rf[3] = 8'h44;
        issue({2'b00, 3'd6, 2'd2, 2'd3});
        n_cmp++; if (bus.result !== 8'h01) begin n_err++; $display("FAIL slte_eq got %h want 01", bus.result); end
    endtask

    task automatic test_branch;
        rf[0] = 8'h55; rf[1] = 8'h55;
        issue({2'b00, 3'd7, 2'd0, 2'd1});
        n_cmp++; if (bus.result !== 8'h01) begin n_err++; $display("FAIL seq got %h want 01", bus.result); end
        rf[2] = 8'h01; rf[3] = 8'h02;
        issue({2'b00, 3'd3, 2'd2, 2'd3});
        n_cmp++; if (bus.eq_flag !== 1'b1 || bus.lt_flag !== 1'b0)
            begin n_err++; $display("FAIL seq_flags got eq=%b lt=%b want 1/0", bus.eq_flag, bus.lt_flag); end
        issue({2'b10, 2'd0, 5'h13});
        n_cmp++; if (bus.branch_taken !== 1'b1 || bus.lut_index !== 5'h13)
            begin n_err++; $display("FAIL beq got bt=%b idx=%h want 1/13", bus.branch_taken, bus.lut_index); end
        n_cmp++; if (bus.reg_write !== 1'b0) begin n_err++; $display("FAIL beq_we got %b want 0", bus.reg_write); end
        issue({2'b10, 2'd1, 5'h07});
        n_cmp++; if (bus.branch_taken !== 1'b0) begin n_err++; $display("FAIL blt got %b want 0", bus.branch_taken); end
        issue({2'b10, 2'd2, 5'h08});
        n_cmp++; if (bus.branch_taken !== 1'b1) begin n_err++; $display("FAIL blte got %b want 1", bus.branch_taken); end
        rf[0] = 8'h03; rf[1] = 8'h09;
        issue({2'b00, 3'd4, 2'd0, 2'd1});
        issue({2'b10, 2'd1, 5'h1E});
        n_cmp++; if (bus.branch_taken !== 1'b1 || bus.lut_index !== 5'h1E)
            begin n_err++; $display("FAIL blt_taken got bt=%b idx=%h want 1/1e", bus.branch_taken, bus.lut_index); end
        issue({2'b10, 2'd0, 5'h1E});
        n_cmp++; if (bus.branch_taken !== 1'b0) begin n_err++; $display("FAIL beq_not got %b want 0", bus.branch_taken); end
    endtask

    task automatic test_lut;
        issue({2'b01, 3'd3, 4'h5});
        issue({2'b01, 3'd6, 2'd2, 2'd0});
        n_cmp++; if (bus.lut_index !== 5'h15 || bus.wb_sel !== 2'd2 || bus.w_addr !== 2'd2 || bus.reg_write !== 1'b1)
            begin n_err++; $display("FAIL lutmem got idx=%h wb=%0d wa=%0d we=%b want 15/2/2/1", bus.lut_index, bus.wb_sel, bus.w_addr, bus.reg_write); end
        issue({2'b01, 3'd2, 4'h7});
        issue({2'b01, 3'd6, 2'd1, 2'd0});
        n_cmp++; if (bus.lut_index !== 5'h07) begin n_err++; $display("FAIL ll got %h want 07", bus.lut_index); end
        issue({2'b01, 3'd3, 4'h5});
        @(negedge clk);
        bus.instr = {2'b01, 3'd6, 2'd2, 2'd0};
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.lut_index !== 5'h00) begin n_err++; $display("FAIL lutmem_reset got %h want 00", bus.lut_index); end
        #2 reset = 1'b0;
    endtask

    task automatic test_lil_liu;
        rf[0] = 8'hFF; rf[2] = 8'h00;
        issue({2'b01, 3'd4, 4'hA});
        n_cmp++; if (bus.result !== 8'hFA || bus.w_addr !== 2'd0 || bus.r_addr1 !== 2'd0 || bus.reg_write !== 1'b1)
            begin n_err++; $display("FAIL lil got %h wa=%0d ra=%0d we=%b want fa/0/0/1", bus.result, bus.w_addr, bus.r_addr1, bus.reg_write); end
        rf[0] = 8'hFA;
        issue({2'b01, 3'd5, 4'h3});
        n_cmp++; if (bus.result !== 8'h3A) begin n_err++; $display("FAIL liu got %h want 3a", bus.result); end
    endtask

    task automatic test_shift;
        rf[0] = 8'h11; rf[3] = 8'h00;
        issue({2'b11, 2'd2, 5'd3});
        n_cmp++; if (bus.result !== 8'h88 || bus.w_addr !== 2'd0 || bus.r_addr1 !== 2'd0)
            begin n_err++; $display("FAIL lsi got %h wa=%0d ra=%0d want 88/0/0", bus.result, bus.w_addr, bus.r_addr1); end
        issue({2'b11, 2'd3, 5'd9});
        n_cmp++; if (bus.result !== 8'h00) begin n_err++; $display("FAIL rsi9 got %h want 00", bus.result); end
        issue({2'b11, 2'd3, 5'd4});
        n_cmp++; if (bus.result !== 8'h01) begin n_err++; $display("FAIL rsi4 got %h want 01", bus.result); end
        rf[2] = 8'h81; rf[1] = 8'h01;
        issue({2'b11, 2'd0, 2'd2, 2'd1, 1'b0});
        n_cmp++; if (bus.result !== 8'h02 || bus.w_addr !== 2'd2 || bus.r_addr1 !== 2'd2 || bus.r_addr2 !== 2'd1)
            begin n_err++; $display("FAIL lsl got %h wa=%0d ra=%0d/%0d want 02/2/2/1", bus.result, bus.w_addr, bus.r_addr1, bus.r_addr2); end
        rf[1] = 8'h07;
        issue({2'b11, 2'd1, 2'd2, 2'd1, 1'b0});
        n_cmp++; if (bus.result !== 8'h01) begin n_err++; $display("FAIL lsr7 got %h want 01", bus.result); end
        rf[1] = 8'h08;
        issue({2'b11, 2'd1, 2'd2, 2'd1, 1'b0});
        n_cmp++; if (bus.result !== 8'h00) begin n_err++; $display("FAIL lsr8 got %h want 00", bus.result); end
    endtask

    task automatic test_mem;
        issue({2'b01, 3'd0, 2'd1, 2'd2});
        n_cmp++; if (bus.mem_write !== 1'b1 || bus.reg_write !== 1'b0 || bus.mem_read !== 1'b0)
            begin n_err++; $display("FAIL sb got mw=%b we=%b mr=%b want 1/0/0", bus.mem_write, bus.reg_write, bus.mem_read); end
        issue({2'b01, 3'd1, 2'd3, 2'd0});
        n_cmp++; if (bus.mem_read !== 1'b1 || bus.reg_write !== 1'b1 || bus.wb_sel !== 2'd1 || bus.w_addr !== 2'd3 || bus.mem_write !== 1'b0)
            begin n_err++; $display("FAIL lb got mr=%b we=%b wb=%0d wa=%0d mw=%b want 1/1/1/3/0", bus.mem_read, bus.reg_write, bus.wb_sel, bus.w_addr, bus.mem_write); end
        issue({2'b01, 3'd7, 4'hF});
        n_cmp++; if (bus.reg_write !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0)
            begin n_err++; $display("FAIL nop got we=%b mw=%b mr=%b want 0/0/0", bus.reg_write, bus.mem_write, bus.mem_read); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        reset = 1'b0;
        bus.instr = 9'b01_111_0000;
        test_reset;
        test_rtype;
        test_compare;
        test_branch;
        test_lut;
        test_lil_liu;
        test_shift;
        test_mem;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
